// File: rtl/signal_change_capture.sv
// signal_change_capture
//   Watches the held, deglitched vector from the hold stage, detects per-bit rising and
//   falling edges qualified by runtime masks, time-stamps each qualifying change with a
//   free-running cycle counter and queues it in a first-word-fall-through event FIFO.
//
// Ports:
//   clk, aresetn        single clock, asynchronous active-low reset
//   enable              1 = changes may be queued; edge tracking runs regardless
//   data_in             monitored vector (synchronous to clk)
//   rise_mask/fall_mask per-bit qualification of rising/falling edges
//   event_valid/ready   handshake for the FIFO head
//   event_ts/value/rise/fall  fields of the FIFO head entry
//   fifo_level          current entry count, 0..FIFO_DEPTH
//   overflow            sticky drop indicator
//   overflow_count      saturating dropped-event count
//   clear_overflow      synchronous clear of overflow and overflow_count
module signal_change_capture #(
    parameter int unsigned DATA_WIDTH = 1,
    parameter int unsigned TS_WIDTH   = 32,
    parameter int unsigned FIFO_DEPTH = 8,
    parameter int unsigned LVL_WIDTH  = 4
) (
    input  logic                  clk,
    input  logic                  aresetn,
    input  logic                  enable,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic [DATA_WIDTH-1:0] rise_mask,
    input  logic [DATA_WIDTH-1:0] fall_mask,
    output logic                  event_valid,
    input  logic                  event_ready,
    output logic [TS_WIDTH-1:0]   event_ts,
    output logic [DATA_WIDTH-1:0] event_value,
    output logic [DATA_WIDTH-1:0] event_rise,
    output logic [DATA_WIDTH-1:0] event_fall,
    output logic [LVL_WIDTH-1:0]  fifo_level,
    output logic                  overflow,
    output logic [15:0]           overflow_count,
    input  logic                  clear_overflow
);

    localparam int unsigned PtrW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

    logic [TS_WIDTH-1:0]   ts_ctr_q;
    logic [DATA_WIDTH-1:0] data_prev_q;
    logic                  primed_q;

    logic [TS_WIDTH-1:0]   mem_ts_q   [FIFO_DEPTH];
    logic [DATA_WIDTH-1:0] mem_val_q  [FIFO_DEPTH];
    logic [DATA_WIDTH-1:0] mem_rise_q [FIFO_DEPTH];
    logic [DATA_WIDTH-1:0] mem_fall_q [FIFO_DEPTH];

    logic [PtrW-1:0]       wr_ptr_q, rd_ptr_q;
    logic [LVL_WIDTH-1:0]  level_q, level_d;
    logic                  overflow_q, overflow_d;
    logic [15:0]           ovf_cnt_q, ovf_cnt_d;

    logic [DATA_WIDTH-1:0] rise, fall;
    logic                  hit, full, empty, pop, push, drop;

    always_comb begin
        rise  = data_in & ~data_prev_q & rise_mask;
        fall  = ~data_in & data_prev_q & fall_mask;
        // The priming edge only captures the reference value.
        hit   = primed_q & enable & (|(rise | fall));
        full  = (level_q == LVL_WIDTH'(FIFO_DEPTH));
        empty = (level_q == '0);
        pop   = ~empty & event_ready;
        // A same-edge pop frees the slot the push needs when full.
        push  = hit & (~full | pop);
        drop  = hit & full & ~pop;
    end

    always_comb begin
        level_d = level_q;
        case ({push, pop})
            2'b10:   level_d = level_q + LVL_WIDTH'(1);
            2'b01:   level_d = level_q - LVL_WIDTH'(1);
            default: level_d = level_q;
        endcase
    end

    always_comb begin
        overflow_d = overflow_q;
        ovf_cnt_d  = ovf_cnt_q;
        if (clear_overflow) begin
            // Clear wins, but a drop on the same edge is still recorded.
            overflow_d = drop;
            ovf_cnt_d  = drop ? 16'd1 : 16'd0;
        end else if (drop) begin
            overflow_d = 1'b1;
            if (ovf_cnt_q != 16'hFFFF) begin
                ovf_cnt_d = ovf_cnt_q + 16'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            ts_ctr_q    <= '0;
            data_prev_q <= '0;
            primed_q    <= 1'b0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            level_q     <= '0;
            overflow_q  <= 1'b0;
            ovf_cnt_q   <= '0;
        end else begin
            ts_ctr_q    <= ts_ctr_q + TS_WIDTH'(1);
            data_prev_q <= data_in;
            primed_q    <= 1'b1;
            level_q     <= level_d;
            overflow_q  <= overflow_d;
            ovf_cnt_q   <= ovf_cnt_d;
            if (push) begin
                wr_ptr_q <= wr_ptr_q + PtrW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PtrW'(1);
            end
        end
    end

    // Storage is reset so the head fields read zero after reset.
    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
                mem_ts_q[i]   <= '0;
                mem_val_q[i]  <= '0;
                mem_rise_q[i] <= '0;
                mem_fall_q[i] <= '0;
            end
        end else if (push) begin
            mem_ts_q[wr_ptr_q]   <= ts_ctr_q;
            mem_val_q[wr_ptr_q]  <= data_in;
            mem_rise_q[wr_ptr_q] <= rise;
            mem_fall_q[wr_ptr_q] <= fall;
        end
    end

    assign event_valid    = ~empty;
    assign event_ts       = mem_ts_q[rd_ptr_q];
    assign event_value    = mem_val_q[rd_ptr_q];
    assign event_rise     = mem_rise_q[rd_ptr_q];
    assign event_fall     = mem_fall_q[rd_ptr_q];
    assign fifo_level     = level_q;
    assign overflow       = overflow_q;
    assign overflow_count = ovf_cnt_q;

endmodule

// File: doc/signal_change_capture.md
Name: signal_change_capture

Overview:
- Downstream consumer of the signal hold/deglitch stage.
- Takes the held, deglitched DATA_WIDTH vector and detects per-bit rising and falling edges, qualified by runtime masks.
- Each qualifying change is time-stamped with a free-running cycle counter and pushed into a small first-word-fall-through event FIFO.
- The FIFO is drained through a valid/ready handshake by the control/status path.

Parameters:
- DATA_WIDTH, 1: width of monitored vector.
- TS_WIDTH, 32: timestamp counter width.
- FIFO_DEPTH, 8: event FIFO entries; power of 2, minimum 2.
- LVL_WIDTH, 4: width of fifo_level; must equal log2(FIFO_DEPTH)+1.

Ports:
- clk  in  1  system clock; single clock domain.
- aresetn  in  1  reset, asynchronous assert, active-low.
- enable  in  1  1 = events may be captured; 0 = edge tracking continues, no pushes.
- data_in  in  DATA_WIDTH  held vector from the upstream hold stage; already synchronous to clk.
- rise_mask  in  DATA_WIDTH  per-bit enable for rising-edge events.
- fall_mask  in  DATA_WIDTH  per-bit enable for falling-edge events.
- event_valid  out  1  FIFO head holds an event.
- event_ready  in  1  consumer accepts the head.
- event_ts  out  TS_WIDTH  timestamp of the head event.
- event_value  out  DATA_WIDTH  data_in value at the event.
- event_rise  out  DATA_WIDTH  bits that rose (masked).
- event_fall  out  DATA_WIDTH  bits that fell (masked).
- fifo_level  out  LVL_WIDTH  current entry count, 0..FIFO_DEPTH.
- overflow  out  1  sticky: at least one event dropped.
- overflow_count  out  16  dropped-event count, saturating.
- clear_overflow  in  1  synchronous clear of overflow and overflow_count.

Behaviour:
- **Reset.** While aresetn=0, all of the following are cleared asynchronously:
  - event_valid=0, fifo_level=0, overflow=0, overflow_count=0;
  - event_ts/value/rise/fall=0;
  - ts_ctr=0, FIFO pointers=0, data_prev=0, primed=0.
  - Reset mid-operation discards all FIFO contents.
- **Priming.** On the first clk edge after reset release:
  - data_prev<=data_in and primed<=1;
  - no event is generated on that edge, whatever the value of data_in.
- **Timestamp.** ts_ctr increments by 1 every edge after reset and wraps modulo 2^TS_WIDTH with no flag.
- **Per-edge detection** (primed=1). Evaluated at every edge:
  - rise = data_in & ~data_prev & rise_mask
  - fall = ~data_in & data_prev & fall_mask
  - hit = enable & |(rise|fall)
  - data_prev<=data_in on every edge, independent of enable and masks. Masked changes are therefore consumed and never reported later.
- **Push.** If hit, entry {ts_ctr (pre-increment value), data_in, rise, fall} is written at wr_ptr.
- **FIFO outputs.** event_* always present the entry at rd_ptr.
  - event_valid = (fifo_level != 0), driven from registers.
  - Latency: data_in changes before edge k → event_valid=1 immediately after edge k, with event_ts = ts_ctr value before edge k.
- **Pop.** Occurs on an edge where event_valid & event_ready.
  - Head data must stay stable while event_valid=1 and event_ready=0.
  - event_ready while empty is ignored.
- **Full.**
  - Push with fifo_level=FIFO_DEPTH and no same-edge pop: the event is dropped, overflow<=1, and overflow_count increments, saturating at 16'hFFFF.
  - Push and pop on the same edge while full: the push is accepted, level is unchanged, no overflow.
- **Empty.**
  - Push and pop on the same edge while empty: the pop is ignored and the push lands; level goes 0→1.
- **Level.** fifo_level adds 1 for each accepted push and subtracts 1 for each pop; both on the same edge means no change.
- **clear_overflow.**
  - overflow<=0 and overflow_count<=0.
  - If a drop occurs on the same edge, clear wins but the new drop is then recorded: overflow=1, count=1.
- **Pointers** are log2(FIFO_DEPTH) bits and wrap naturally.

Test Plan:
1. **Reset and priming.** Hold data_in=1 through reset release with both masks=all-ones → no event ever; fifo_level=0, event_valid=0.
2. **Single rise latency.** DATA_WIDTH=4, masks=4'hF, data_in 4'h0→4'h5 before edge k → event_valid=1 after edge k with:
   - event_rise=4'h5, event_fall=0, event_value=4'h5;
   - event_ts = cycles since reset release minus 1.
3. **Masking and enable.**
   - rise_mask=4'h1 and data_in 0→4'h3 → event_rise=4'h1.
   - enable=0 then 4'h3→0 → no event, and data_prev still updates.
   - Re-enable with data_in unchanged → no event.
4. **Overflow with backpressure.** event_ready=0, FIFO_DEPTH=8, 10 toggles → fifo_level=8, overflow=1, overflow_count=2.
   - Then pop all 8 → timestamps strictly increasing, first 8 events in order.
   - clear_overflow → count=0.
5. **Full with simultaneous push and pop.** With the FIFO full and event_ready=1, a change lands → level stays 8, overflow_count unchanged, the new event is at the tail.
6. **Reset mid-operation.** Assert aresetn=0 asynchronously with 5 entries queued → event_valid and fifo_level drop to 0 without a clk edge.
   - After release, the next change is timestamped from 0 and goes through the priming edge first.
